// File: rtl/usb_packet_rx.sv
// USB packet receiver: line decode, SYNC detection, NRZI decode, bit unstuffing,
// PID check, byte assembly and EOP detection, advanced only on bit_en strobes.
module usb_packet_rx #(
   parameter int FULL_SPEED = 0,
   parameter int MAX_BYTES  = 8
) (
   input  logic                           clk,
   input  logic                           reset,
   input  logic                           bit_en,
   input  logic [1:0]                     d_port,
   output logic                           rx_active,
   output logic [3:0]                     pid,
   output logic                           pid_valid,
   output logic                           pid_err,
   output logic [7:0]                     data,
   output logic                           data_valid,
   output logic [$clog2(MAX_BYTES+1)-1:0] byte_cnt,
   output logic                           eop,
   output logic                           eop_aligned,
   output logic                           err
);
   localparam int CW = $clog2(MAX_BYTES+1);

   typedef enum logic [2:0] {
      ST_IDLE, ST_SYNC, ST_PID, ST_DATA, ST_WAIT_EOP, ST_EOP
   } state_t;

   state_t     state;
   logic       prev_j;
   logic [2:0] sync_cnt;
   logic [2:0] ones;
   logic [2:0] bit_cnt;
   logic [6:0] shreg;

   logic       se0, se1, is_j, is_k, nrzi_bit, exp_k;
   logic [7:0] nxt_byte;

   always_comb begin
      se0      = (d_port == 2'b00);
      se1      = (d_port == 2'b11);
      is_j     = (FULL_SPEED != 0) ? (d_port == 2'b10) : (d_port == 2'b01);
      is_k     = (FULL_SPEED != 0) ? (d_port == 2'b01) : (d_port == 2'b10);
      nrzi_bit = (is_j == prev_j);
      nxt_byte = {nrzi_bit, shreg};
      // SYNC tail after the opening K is J K J K J K K
      exp_k    = sync_cnt[0] || (sync_cnt == 3'd6);
   end

   function automatic logic pid_ok(input logic [7:0] b);
      logic known;
      case (b[3:0])
         4'b0001, 4'b1001, 4'b0101, 4'b1101, 4'b0011,
         4'b1011, 4'b0010, 4'b1010, 4'b1110, 4'b1100: known = 1'b1;
         default:                                     known = 1'b0;
      endcase
      return known && (b[7:4] == ~b[3:0]);
   endfunction

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state       <= ST_IDLE;
         prev_j      <= 1'b1;
         sync_cnt    <= '0;
         ones        <= '0;
         bit_cnt     <= '0;
         shreg       <= '0;
         rx_active   <= 1'b0;
         pid         <= '0;
         pid_valid   <= 1'b0;
         pid_err     <= 1'b0;
         data        <= '0;
         data_valid  <= 1'b0;
         byte_cnt    <= '0;
         eop         <= 1'b0;
         eop_aligned <= 1'b0;
         err         <= 1'b0;
      end else begin
         pid_valid  <= 1'b0;
         pid_err    <= 1'b0;
         data_valid <= 1'b0;
         eop        <= 1'b0;
         if (bit_en) begin
            if (is_j || is_k) prev_j <= is_j;
            case (state)
               ST_IDLE: begin
                  if (is_k) begin
                     state    <= ST_SYNC;
                     sync_cnt <= '0;
                  end
               end
               ST_SYNC: begin
                  if ((is_k && exp_k) || (is_j && !exp_k)) begin
                     if (sync_cnt == 3'd6) begin
                        state     <= ST_PID;
                        rx_active <= 1'b1;
                        byte_cnt  <= '0;
                        err       <= 1'b0;
                        ones      <= 3'd1;
                        bit_cnt   <= '0;
                     end else begin
                        sync_cnt <= sync_cnt + 3'd1;
                     end
                  end else begin
                     state <= ST_IDLE;
                  end
               end
               ST_PID, ST_DATA: begin
                  if (se0) begin
                     state <= ST_EOP;
                  end else if (se1) begin
                     err   <= 1'b1;
                     state <= ST_WAIT_EOP;
                  end else if (ones == 3'd6) begin
                     // bit after six ones: a 0 is stuffing, a 1 is a stuff error
                     if (nrzi_bit) begin
                        err   <= 1'b1;
                        state <= ST_WAIT_EOP;
                     end else begin
                        ones <= '0;
                     end
                  end else begin
                     ones    <= nrzi_bit ? ones + 3'd1 : 3'd0;
                     shreg   <= nxt_byte[7:1];
                     bit_cnt <= bit_cnt + 3'd1;
                     if (bit_cnt == 3'd7) begin
                        if (state == ST_PID) begin
                           pid <= nxt_byte[3:0];
                           if (pid_ok(nxt_byte)) begin
                              pid_valid <= 1'b1;
                              state     <= ST_DATA;
                           end else begin
                              pid_err <= 1'b1;
                              state   <= ST_WAIT_EOP;
                           end
                        end else if (byte_cnt == CW'(MAX_BYTES)) begin
                           err   <= 1'b1;
                           state <= ST_WAIT_EOP;
                        end else begin
                           data       <= nxt_byte;
                           data_valid <= 1'b1;
                           byte_cnt   <= byte_cnt + CW'(1);
                        end
                     end
                  end
               end
               ST_WAIT_EOP: begin
                  if (se0) state <= ST_EOP;
               end
               ST_EOP: begin
                  if (is_j) begin
                     eop         <= 1'b1;
                     eop_aligned <= (bit_cnt == 3'd0);
                     rx_active   <= 1'b0;
                     state       <= ST_IDLE;
                  end else if (is_k || se1) begin
                     err       <= 1'b1;
                     rx_active <= 1'b0;
                     state     <= ST_IDLE;
                  end
               end
               default: state <= ST_IDLE;
            endcase
         end
      end
   end
endmodule
